sd_cmd_seq: RTL and testbench

SD-card command sequencer for the SPI-mode MicroSD path. Accepts one command request (index plus 32-bit argument), drives the existing `spi` byte engine one byte at a time to send the 6-byte command frame with a generated CRC7, then polls with 0xFF bytes until an R1 response arrives or the poll limit expires. It sits between the card-init/block-read FSMs and `spi`, and is the only block that toggles the engine's `en`/`reset` pins.

---
 rtl/sd_pkg.sv | 30 +++
 rtl/sd_crc7.sv | 24 ++
 rtl/sd_cmd_seq.sv | 176 +++++++++++++++++
 tb/tb_sd_cmd_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD command and data paths.
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_REARM,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0] SD_START_BITS      = 2'b01;
    localparam logic [7:0] SD_FILL            = 8'hFF;
    localparam logic [6:0] CRC7_POLY          = 7'h09;
    localparam int         R1_IDLE_BIT        = 0;
    localparam int         R1_ILLEGAL_CMD_BIT = 2;

    // Folds one byte, MSB first, into a CRC7 (x^7 + x^3 + 1).
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] din);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ din[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ CRC7_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-wide CRC7 accumulator; clr together with en restarts from zero and
// folds din in the same cycle.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [6:0] crc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7_byte(clr ? 7'd0 : crc, din);
        end else if (clr) begin
            crc <= '0;
        end
    end

endmodule

// File: rtl/sd_cmd_seq.sv
// SD SPI-mode command sequencer: sends a 6-byte command frame through the
// byte engine, then polls with 0xFF until an R1 byte or the poll limit.
module sd_cmd_seq
    import sd_pkg::*;
#(
    parameter int MAX_POLL   = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic        timeout,
    output logic [7:0]  spi_datain,
    output logic        spi_en,
    output logic        spi_rst,
    input  logic [7:0]  spi_dataout,
    input  logic        spi_done
);

    seq_state_t  state_q, state_d;
    logic [2:0]  byte_q, byte_d;
    logic [7:0]  poll_q, poll_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  rx_q, rx_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [7:0]  datain_q, datain_d;
    logic [7:0]  r1_q, r1_d;
    logic        tmo_q, tmo_d;

    logic        crc_clr, crc_en;
    logic [7:0]  crc_din;
    logic [6:0]  crc;
    logic [2:0]  byte_nxt;
    logic [7:0]  frame_nxt;

    function automatic logic [7:0] frame_byte(input logic [2:0] k, input logic [5:0] idx,
                                              input logic [31:0] arg, input logic [6:0] crc_v);
        case (k)
            3'd0:    return {SD_START_BITS, idx};
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            default: return {crc_v, 1'b1};
        endcase
    endfunction

    sd_crc7 u_crc7 (
        .clk   (clk),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc)
    );

    assign byte_nxt  = byte_q + 3'd1;
    assign frame_nxt = frame_byte(byte_nxt, idx_q, arg_q, crc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            byte_q   <= '0;
            poll_q   <= '0;
            gap_q    <= '0;
            rx_q     <= SD_FILL;
            idx_q    <= '0;
            arg_q    <= '0;
            datain_q <= SD_FILL;
            r1_q     <= SD_FILL;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
            rx_q     <= rx_d;
            idx_q    <= idx_d;
            arg_q    <= arg_d;
            datain_q <= datain_d;
            r1_q     <= r1_d;
            tmo_q    <= tmo_d;
        end
    end

    // Each frame byte is folded into the CRC on the cycle it is loaded, so the
    // CRC register is complete by the time byte 5 is built from it.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
        rx_d     = rx_q;
        idx_d    = idx_q;
        arg_d    = arg_q;
        datain_d = datain_q;
        r1_d     = r1_q;
        tmo_d    = tmo_q;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        crc_din  = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    idx_d    = cmd_index;
                    arg_d    = cmd_arg;
                    byte_d   = '0;
                    poll_d   = '0;
                    datain_d = {SD_START_BITS, cmd_index};
                    crc_clr  = 1'b1;
                    crc_en   = 1'b1;
                    crc_din  = {SD_START_BITS, cmd_index};
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (spi_done) begin
                    rx_d    = spi_dataout;
                    gap_d   = '0;
                    state_d = ST_REARM;
                end
            end
            ST_REARM: begin
                if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    if (byte_q != 3'd5) begin
                        byte_d   = byte_nxt;
                        datain_d = frame_nxt;
                        crc_en   = (byte_nxt != 3'd5);
                        crc_din  = frame_nxt;
                        state_d  = ST_SEND;
                    end else if (poll_q == 8'd0) begin
                        datain_d = SD_FILL;
                        poll_d   = 8'd1;
                        state_d  = ST_SEND;
                    end else if (!rx_q[7]) begin
                        r1_d    = rx_q;
                        tmo_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if (poll_q == 8'(MAX_POLL)) begin
                        r1_d    = SD_FILL;
                        tmo_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        datain_d = SD_FILL;
                        poll_d   = poll_q + 8'd1;
                        state_d  = ST_SEND;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign spi_en     = (state_q == ST_SEND);
    assign spi_rst    = (state_q != ST_SEND);
    assign spi_datain = datain_q;
    assign resp_r1    = r1_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Directed bench for sd_cmd_seq with a behavioural byte-engine/card model.
module tb_sd_cmd_seq;

    localparam int MAX_POLL   = 8;
    localparam int GAP_CYCLES = 2;
    localparam int BYTE_T     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        busy, resp_valid, timeout, spi_en, spi_rst;
    logic [7:0]  resp_r1, spi_datain;
    logic [7:0]  spi_dataout = 8'hFF;
    logic        spi_done = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0] mosi_log [0:1023];
    logic [7:0] resp_tab [0:15];
    int xfer_total = 0;
    int cmd_base = 0;
    int resp_len = 0;
    int eng_cnt = 0;
    int rv_count = 0;
    int rv_base = 0;
    int rv_hold = 0;
    int gap_run = 0;
    int min_gap = 1000;

    always #5 clk = ~clk;

    sd_cmd_seq #(.MAX_POLL(MAX_POLL), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .cmd_start   (cmd_start),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_r1     (resp_r1),
        .timeout     (timeout),
        .spi_datain  (spi_datain),
        .spi_en      (spi_en),
        .spi_rst     (spi_rst),
        .spi_dataout (spi_dataout),
        .spi_done    (spi_done)
    );

    function automatic logic [7:0] pick_resp(input int n);
        if (n >= 6 && (n - 6) < resp_len) return resp_tab[n - 6];
        return 8'hFF;
    endfunction

    // Byte engine plus card: frame bytes answer 0xFF, poll bytes come from resp_tab.
    always @(posedge clk) begin
        if (spi_rst || !spi_en) begin
            spi_done <= 1'b0;
            eng_cnt  <= 0;
        end else if (!spi_done) begin
            if (eng_cnt == BYTE_T - 1) begin
                spi_done             <= 1'b1;
                mosi_log[xfer_total] <= spi_datain;
                spi_dataout          <= pick_resp(xfer_total - cmd_base);
                xfer_total           <= xfer_total + 1;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // Counts resp_valid pulses and the shortest engine-reset gap between bytes.
    always @(posedge clk) begin
        if (resp_valid) rv_count <= rv_count + 1;
        if (!busy) begin
            gap_run <= 0;
        end else if (spi_rst) begin
            gap_run <= gap_run + 1;
        end else begin
            if (gap_run > 0 && gap_run < min_gap) min_gap <= gap_run;
            gap_run <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkMosi(input int n, input logic [7:0] expected);
        checkOutput($sformatf("mosi_byte%0d", n), 32'(mosi_log[cmd_base + n]), 32'(expected));
    endtask

    // Issues one command from a negedge and waits for its response pulse;
    // glitch>0 pulses a stray CMD55 start that many cycles into the command.
    task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input int glitch);
        logic got;
        cmd_base  = xfer_total;
        rv_base   = rv_count;
        cmd_index = idx;
        cmd_arg   = arg;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        checkOutput("spi_en_after_start", 32'(spi_en), 32'd1);
        got = 1'b0;
        for (int c = 1; c <= 800 && !got; c++) begin
            if (glitch != 0 && c == glitch) begin
                cmd_index = 6'd55;
                cmd_start = 1'b1;
            end else begin
                cmd_start = 1'b0;
            end
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        cmd_start = 1'b0;
        checkOutput("resp_valid_seen", 32'(got), 32'd1);
        @(negedge clk);
        checkOutput("busy_after_resp", 32'(busy), 32'd0);
        checkOutput("resp_valid_one_cycle", 32'(resp_valid), 32'd0);
        checkOutput("resp_valid_count", 32'(rv_count - rv_base), 32'd1);
    endtask

    initial begin
        $display("[TB] sd_cmd_seq directed test start");
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_r1", 32'(resp_r1), 32'hFF);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_spi_en", 32'(spi_en), 32'd0);
        checkOutput("rst_spi_rst", 32'(spi_rst), 32'd1);
        checkOutput("rst_spi_datain", 32'(spi_datain), 32'hFF);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] CMD0, R1 on first poll");
        resp_tab[0] = 8'h01;
        resp_len = 1;
        applyStimulus(6'd0, 32'h0, 0);
        checkMosi(0, 8'h40); checkMosi(1, 8'h00); checkMosi(2, 8'h00);
        checkMosi(3, 8'h00); checkMosi(4, 8'h00); checkMosi(5, 8'h95);
        checkMosi(6, 8'hFF);
        checkOutput("cmd0_xfers", 32'(xfer_total - cmd_base), 32'd7);
        checkOutput("cmd0_r1", 32'(resp_r1), 32'h01);
        checkOutput("cmd0_timeout", 32'(timeout), 32'd0);

        $display("[TB] CMD8, R1 on third poll");
        resp_tab[0] = 8'hFF; resp_tab[1] = 8'hFF; resp_tab[2] = 8'h01;
        resp_len = 3;
        applyStimulus(6'd8, 32'h0000_01AA, 0);
        checkMosi(0, 8'h48); checkMosi(1, 8'h00); checkMosi(2, 8'h00);
        checkMosi(3, 8'h01); checkMosi(4, 8'hAA); checkMosi(5, 8'h87);
        checkMosi(8, 8'hFF);
        checkOutput("cmd8_xfers", 32'(xfer_total - cmd_base), 32'd9);
        checkOutput("cmd8_r1", 32'(resp_r1), 32'h01);
        checkOutput("cmd8_timeout", 32'(timeout), 32'd0);

        $display("[TB] CMD17, card never answers");
        resp_len = 0;
        applyStimulus(6'd17, 32'h0, 0);
        checkMosi(0, 8'h51);
        checkMosi(13, 8'hFF);
        checkOutput("cmd17_xfers", 32'(xfer_total - cmd_base), 32'd14);
        checkOutput("cmd17_r1", 32'(resp_r1), 32'hFF);
        checkOutput("cmd17_timeout", 32'(timeout), 32'd1);

        $display("[TB] stray CMD55 start during CMD0 frame");
        resp_tab[0] = 8'h01;
        resp_len = 1;
        applyStimulus(6'd0, 32'h0, 10);
        checkMosi(0, 8'h40); checkMosi(1, 8'h00); checkMosi(4, 8'h00);
        checkMosi(5, 8'h95);
        checkOutput("glitch_xfers", 32'(xfer_total - cmd_base), 32'd7);
        checkOutput("glitch_r1", 32'(resp_r1), 32'h01);
        repeat (60) @(negedge clk);
        checkOutput("glitch_idle_busy", 32'(busy), 32'd0);
        checkOutput("glitch_resp_count", 32'(rv_count - rv_base), 32'd1);

        $display("[TB] reset during frame byte 3");
        rv_hold   = rv_count;
        cmd_base  = xfer_total;
        cmd_index = 6'd0;
        cmd_arg   = 32'h0;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int c = 0; c < 300 && (xfer_total - cmd_base) < 3; c++) @(negedge clk);
        checkOutput("abort_reach_byte3", 32'(xfer_total - cmd_base), 32'd3);
        repeat (4) @(negedge clk);
        checkOutput("abort_sending", 32'(spi_en), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_spi_en", 32'(spi_en), 32'd0);
        checkOutput("abort_spi_rst", 32'(spi_rst), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_resp_r1", 32'(resp_r1), 32'hFF);
        checkOutput("abort_spi_datain", 32'(spi_datain), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_no_resp", 32'(rv_count - rv_hold), 32'd0);
        applyStimulus(6'd0, 32'h0, 0);
        checkMosi(0, 8'h40);
        checkMosi(5, 8'h95);
        checkOutput("post_abort_r1", 32'(resp_r1), 32'h01);

        $display("[TB] back-to-back CMD55 right after busy falls");
        applyStimulus(6'd55, 32'h0, 0);
        checkMosi(0, 8'h77);
        checkMosi(6, 8'hFF);
        checkOutput("b2b_xfers", 32'(xfer_total - cmd_base), 32'd7);
        checkOutput("b2b_r1", 32'(resp_r1), 32'h01);
        checkOutput("min_rearm_gap", 32'(min_gap), 32'(GAP_CYCLES));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
